fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order instruction-memory reads, buffers the
// returned instructions for decode, and flushes on redirect while dropping stale responses.
module fetch_queue #(
    parameter int              PC_W     = 13,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect,
    input  logic [PC_W-1:0]         redirect_pc,
    output logic                    imem_req_valid,
    output logic [PC_W-1:0]         imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [INSTR_W-1:0]      imem_rsp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [PC_W-1:0]         out_pc,
    output logic [PC_W-1:0]         out_pc_plus1,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    entry_pc   [DEPTH];
    logic [INSTR_W-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0]   filled;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   fill;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   pend;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   drop_next;
    logic               accept;
    logic               pop;
    logic               rsp_drop;
    logic               rsp_fill;

    // Reset is folded into the request valid so nothing is issued while held in reset.
    assign imem_req_valid = rst && (count < DEPTH_C) && !redirect;
    assign imem_req_addr  = fetch_pc;
    assign out_valid      = (count != '0) && filled[head] && !redirect;
    assign out_instr      = entry_data[head];
    assign out_pc         = entry_pc[head];
    assign out_pc_plus1   = out_pc + PC_ONE;

    assign accept   = imem_req_valid && imem_req_ready;
    assign pop      = out_valid && out_ready;
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pend != '0);

    // Every in-flight request becomes a drop on redirect; a response arriving in the
    // redirect cycle belongs to the oldest of them and is consumed immediately.
    always_comb begin
        drop_next = drop_cnt + pend;
        if (imem_rsp_valid && (drop_next != '0)) begin
            drop_next = drop_next - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
            filled   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc[i]   <= '0;
                entry_data[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            filled   <= '0;
            drop_cnt <= drop_next;
        end else begin
            if (accept) begin
                entry_pc[tail] <= fetch_pc;
                filled[tail]   <= 1'b0;
                tail           <= tail + PTR_ONE;
                fetch_pc       <= fetch_pc + PC_ONE;
            end
            // The fill slot is always unfilled and the head slot always filled, so these never collide.
            if (rsp_fill) begin
                entry_data[fill] <= imem_rsp_data;
                filled[fill]     <= 1'b1;
                fill             <= fill + PTR_ONE;
            end
            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + PTR_ONE;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_ONE;
            end
            count <= count + CNT_W'(accept) - CNT_W'(pop);
            pend  <= pend + CNT_W'(accept) - CNT_W'(rsp_fill);
        end
    end

endmodule
